cache_hit_monitor: RTL

Passive 2-way set-associative cache model that snoops one memory access stream of the single-cycle CPU (instruction fetch address or data-memory address on MemRead/MemWrite) and classifies each access as hit or miss in hardware. It sits downstream of the CPU's IM/DM address ports, alongside the address trace that feeds offline cache analysis. It produces per-access hit/miss pulses and running counters, and never stalls the CPU.

---
 rtl/cache_hit_monitor.sv | 128 ++++++++++++
 1 files changed

// File: rtl/cache_hit_monitor.sv
// Passive 2-way set-associative cache model that classifies a snooped CPU access stream
// as hit/miss, with per-access pulses and saturating access/hit counters.
module cache_hit_monitor #(
    parameter int OFFSET_W = 4,
    parameter int INDEX_W  = 6,
    parameter int CNT_W    = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             req_i,
    input  logic [31:0]      addr_i,
    input  logic             flush_i,
    input  logic             clr_i,
    output logic             hit_o,
    output logic             miss_o,
    output logic [CNT_W-1:0] access_cnt_o,
    output logic [CNT_W-1:0] hit_cnt_o
);

    localparam int TAG_W = 32 - OFFSET_W - INDEX_W;
    localparam int SETS  = 1 << INDEX_W;
    localparam int LINE_W = 32 - OFFSET_W;

    // Stage 1: captured access (offset bits are never needed, so not stored)
    logic              s1_vld_q,  s1_vld_d;
    logic [LINE_W-1:0] s1_line_q, s1_line_d;

    logic [SETS-1:0]  valid0_q, valid0_d;
    logic [SETS-1:0]  valid1_q, valid1_d;
    logic [SETS-1:0]  lru_q,    lru_d;
    logic [TAG_W-1:0] tag0_q [SETS];
    logic [TAG_W-1:0] tag1_q [SETS];

    logic             hit_q,  hit_d;
    logic             miss_q, miss_d;
    logic [CNT_W-1:0] acc_q,  acc_d;
    logic [CNT_W-1:0] hcnt_q, hcnt_d;

    logic [INDEX_W-1:0] s2_idx;
    logic [TAG_W-1:0]   s2_tag;
    logic               hit0, hit1, s2_hit;
    logic               victim;
    logic               fill_en;

    assign s2_idx = s1_line_q[INDEX_W-1:0];
    assign s2_tag = s1_line_q[LINE_W-1:INDEX_W];
    assign hit0   = valid0_q[s2_idx] && (tag0_q[s2_idx] == s2_tag);
    assign hit1   = valid1_q[s2_idx] && (tag1_q[s2_idx] == s2_tag);
    assign s2_hit = hit0 || hit1;
    assign victim = !valid0_q[s2_idx] ? 1'b0 :
                    !valid1_q[s2_idx] ? 1'b1 : lru_q[s2_idx];
    // A flush at the classification edge discards the fill
    assign fill_en = s1_vld_q && !s2_hit && !flush_i;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        s1_vld_d  = req_i;
        s1_line_d = req_i ? addr_i[31:OFFSET_W] : s1_line_q;
        valid0_d  = valid0_q;
        valid1_d  = valid1_q;
        lru_d     = lru_q;
        hit_d     = s1_vld_q && s2_hit;
        miss_d    = s1_vld_q && !s2_hit;
        acc_d     = acc_q;
        hcnt_d    = hcnt_q;

        if (s1_vld_q) begin
            if (s2_hit) begin
                lru_d[s2_idx] = hit0 ? 1'b1 : 1'b0;
            end else begin
                if (victim) valid1_d[s2_idx] = 1'b1;
                else        valid0_d[s2_idx] = 1'b1;
                lru_d[s2_idx] = ~victim;
            end
            if (acc_q != '1)               acc_d  = acc_q + 1'b1;
            if (s2_hit && (hcnt_q != '1))  hcnt_d = hcnt_q + 1'b1;
        end

        if (flush_i) begin
            valid0_d = '0;
            valid1_d = '0;
            lru_d    = '0;
        end
        if (clr_i) begin
            acc_d  = '0;
            hcnt_d = '0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s1_vld_q  <= 1'b0;
            s1_line_q <= '0;
            valid0_q  <= '0;
            valid1_q  <= '0;
            lru_q     <= '0;
            hit_q     <= 1'b0;
            miss_q    <= 1'b0;
            acc_q     <= '0;
            hcnt_q    <= '0;
        end else begin
            s1_vld_q  <= s1_vld_d;
            s1_line_q <= s1_line_d;
            valid0_q  <= valid0_d;
            valid1_q  <= valid1_d;
            lru_q     <= lru_d;
            hit_q     <= hit_d;
            miss_q    <= miss_d;
            acc_q     <= acc_d;
            hcnt_q    <= hcnt_d;
        end
    end

    // NOTE: tag storage is not reset; valid bits gate every compare, so stale tags are harmless.
    always_ff @(posedge clk_i) begin
        if (fill_en) begin
            if (victim) tag1_q[s2_idx] <= s2_tag;
            else        tag0_q[s2_idx] <= s2_tag;
        end
    end

    assign hit_o        = hit_q;
    assign miss_o       = miss_q;
    assign access_cnt_o = acc_q;
    assign hit_cnt_o    = hcnt_q;

endmodule
